// File: rtl/dbguart_bridge.sv
// Debug-UART to message-fabric bridge: decodes 'W'/'R' frames from the UART RX FIFO,
// issues relocated bus requests and returns status/read data through the UART TX FIFO.
module dbguart_bridge #(
    parameter int  DWID    = 128,
    parameter int  AWID    = 32,
    parameter int  TWID    = 5,
    parameter int  TMO_CYC = 1024,
    localparam int BWID    = (DWID == 512) ? 6 : (DWID == 256) ? 5 :
                             (DWID == 128) ? 4 : (DWID == 64) ? 3 : 2,
    localparam int WID     = 2 + TWID + BWID + AWID + DWID
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      rxdata,
    input  logic            rx_valid,
    output logic            read_rx,
    output logic [7:0]      txdata,
    input  logic            tx_empty,
    output logic            write_tx,
    output logic [WID-1:0]  msg_out,
    input  logic            msg_out_ack,
    input  logic [WID-1:0]  msg_in,
    output logic            msg_in_ack,
    input  logic [AWID-1:0] base_address,
    input  logic            enable,
    output logic            busy
);
    localparam int ABYTES = AWID / 8;
    localparam int DBYTES = DWID / 8;
    localparam int TMW    = $clog2(TMO_CYC + 1);
    localparam logic [BWID-1:0] SIZE = BWID'($clog2(DBYTES));

    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_RD  = 2'b10;
    localparam logic [1:0] OP_RSP = 2'b11;
    localparam logic [7:0] CH_W = 8'h57, CH_R = 8'h52, CH_E = 8'h45;
    localparam logic [7:0] CH_K = 8'h4B, CH_D = 8'h44, CH_T = 8'h54;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, ISSUE, WAIT_RSP, TX_HDR, TX_DATA} state_t;

    state_t          state, state_nx;
    logic [7:0]      cnt, cnt_nx;
    logic            is_wr, is_wr_nx;
    logic [7:0]      hdr, hdr_nx;
    logic [TWID-1:0] tag, tag_nx, req_tag, req_tag_nx;
    logic [TMW-1:0]  tmo_cnt, tmo_nx;
    logic [AWID-1:0] rx_addr, addr_nx;
    logic [DWID-1:0] rx_data, data_nx, rsp_data, rsp_nx;
    logic [WID-1:0]  msg_out_nx;
    logic [7:0]      txdata_nx;
    logic            write_tx_nx, read_rx_nx, msg_in_ack_nx;
    logic            rx_take, in_take, rsp_match, tmo_hit, go_issue;
    logic [1:0]      in_op;
    logic [TWID-1:0] in_tag;
    logic            in_fields_unused;

    assign in_op            = msg_in[WID-1 -: 2];
    assign in_tag           = msg_in[WID-3 -: TWID];
    assign in_fields_unused = ^msg_in[DWID +: (AWID + BWID)];

    // While msg_in_ack is high the producer is still replacing the consumed message,
    // so whatever sits on msg_in in that cycle is ignored.
    assign in_take   = (in_op != 2'b00) && !msg_in_ack;
    assign rsp_match = in_take && (in_op == OP_RSP) && (in_tag == req_tag);
    assign rx_take   = read_rx && enable;
    assign tmo_hit   = tmo_cnt >= TMW'(TMO_CYC - 1);

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        is_wr_nx    = is_wr;
        hdr_nx      = hdr;
        tag_nx      = tag;
        req_tag_nx  = req_tag;
        tmo_nx      = tmo_cnt;
        addr_nx     = rx_addr;
        data_nx     = rx_data;
        rsp_nx      = rsp_data;
        msg_out_nx  = msg_out;
        txdata_nx   = txdata;
        write_tx_nx = 1'b0;
        go_issue    = 1'b0;
        case (state)
            IDLE: if (rx_take) begin
                cnt_nx = '0;
                if (rxdata == CH_W || rxdata == CH_R) begin
                    is_wr_nx = (rxdata == CH_W);
                    state_nx = ADDR;
                end else begin
                    hdr_nx   = CH_E;
                    state_nx = TX_HDR;
                end
            end
            ADDR: if (rx_take) begin
                addr_nx = (rx_addr << 8) | AWID'(rxdata);
                cnt_nx  = cnt + 8'd1;
                if (cnt == 8'(ABYTES - 1)) begin
                    cnt_nx = '0;
                    if (is_wr) state_nx = DATA;
                    else       go_issue = 1'b1;
                end
            end
            DATA: if (rx_take) begin
                data_nx = (rx_data << 8) | DWID'(rxdata);
                cnt_nx  = cnt + 8'd1;
                if (cnt == 8'(DBYTES - 1)) begin
                    cnt_nx   = '0;
                    go_issue = 1'b1;
                end
            end
            ISSUE: begin
                tmo_nx = tmo_cnt + TMW'(1);
                if (msg_out_ack || tmo_hit) begin
                    msg_out_nx = '0;
                    tag_nx     = tag + TWID'(1);
                    if (!msg_out_ack) begin
                        hdr_nx   = CH_T;
                        state_nx = TX_HDR;
                    end else if (is_wr) begin
                        hdr_nx   = CH_K;
                        state_nx = TX_HDR;
                    end else begin
                        state_nx = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                tmo_nx = tmo_cnt + TMW'(1);
                if (rsp_match) begin
                    rsp_nx   = msg_in[DWID-1:0];
                    hdr_nx   = CH_D;
                    state_nx = TX_HDR;
                end else if (tmo_hit) begin
                    hdr_nx   = CH_T;
                    state_nx = TX_HDR;
                end
            end
            TX_HDR: if (tx_empty && !write_tx) begin
                write_tx_nx = 1'b1;
                txdata_nx   = hdr;
                cnt_nx      = '0;
                state_nx    = (hdr == CH_D) ? TX_DATA : IDLE;
            end
            TX_DATA: if (tx_empty && !write_tx) begin
                write_tx_nx = 1'b1;
                txdata_nx   = rsp_data[DWID-1 -: 8];
                rsp_nx      = rsp_data << 8;
                cnt_nx      = cnt + 8'd1;
                if (cnt == 8'(DBYTES - 1)) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // The final frame byte is folded in here so the request appears one cycle after its pop.
        if (go_issue) begin
            state_nx   = ISSUE;
            tmo_nx     = '0;
            req_tag_nx = tag;
            msg_out_nx = {is_wr ? OP_WR : OP_RD, tag, SIZE, base_address + addr_nx,
                          is_wr ? data_nx : {DWID{1'b0}}};
        end
        if (!enable) begin
            state_nx    = IDLE;
            msg_out_nx  = '0;
            write_tx_nx = 1'b0;
        end
        read_rx_nx    = rx_valid && !read_rx && (!enable || state_nx inside {IDLE, ADDR, DATA});
        msg_in_ack_nx = in_take;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            is_wr      <= 1'b0;
            hdr        <= '0;
            tag        <= '0;
            req_tag    <= '0;
            tmo_cnt    <= '0;
            msg_out    <= '0;
            txdata     <= '0;
            write_tx   <= 1'b0;
            read_rx    <= 1'b0;
            msg_in_ack <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            is_wr      <= is_wr_nx;
            hdr        <= hdr_nx;
            tag        <= tag_nx;
            req_tag    <= req_tag_nx;
            tmo_cnt    <= tmo_nx;
            msg_out    <= msg_out_nx;
            txdata     <= txdata_nx;
            write_tx   <= write_tx_nx;
            read_rx    <= read_rx_nx;
            msg_in_ack <= msg_in_ack_nx;
            busy       <= (state_nx != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        rx_addr  <= addr_nx;
        rx_data  <= data_nx;
        rsp_data <= rsp_nx;
    end
endmodule

// File: doc/dbguart_bridge.md
# dbguart_bridge

Debug-UART to bus-message bridge; the working successor to the stub debug-UART operator. Consumes binary command frames from the UART receive FIFO and issues write/read messages on `msg_out` with `base_address` relocation. Collects read responses from `msg_in` and serialises status and data back through the UART transmit FIFO. Sits between the UART core and the message fabric, one instance per debug port.

## Interface

- `DWID`, 128: data width in bits; multiple of 8, range 32..512.
- `AWID`, 32: address width in bits; multiple of 8.
- `TWID`, 5: transaction tag width.
- `BWID`, derived: 6/5/4/3/2 for `DWID` = 512/256/128/64/other.
- `WID`, derived: 2+TWID+BWID+AWID+DWID.
- `TMO_CYC`, 1024: response timeout in clk cycles; must be ≥2.
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `rxdata` in 8: head byte of the UART RX FIFO.
- `rx_valid` in 1: RX FIFO non-empty.
- `read_rx` out 1: one-cycle pop of the RX FIFO.
- `txdata` out 8: byte to transmit.
- `tx_empty` in 1: TX FIFO can accept a byte.
- `write_tx` out 1: one-cycle push of `txdata`.
- `msg_out` out WID: request message, `{op[1:0], tag, size, addr, data}` MSB→LSB.
- `msg_out_ack` in 1: fabric accepted `msg_out`.
- `msg_in` in WID: response message, same layout.
- `msg_in_ack` out 1: one-cycle consume of `msg_in`.
- `base_address` in AWID: added to every received address.
- `enable` in 1: bridge enable.
- `busy` out 1: FSM not in IDLE.

## Operation

- Message op field: 00 = none (empty), 01 = write, 10 = read request, 11 = read response.
  - A message is valid iff op ≠ 00.
  - `size` = log2(DWID/8).
  - Read requests carry data = 0.
- Frame format on RX:
  - Command byte: 0x57 'W' or 0x52 'R'.
  - Then AWID/8 address bytes, MSB first.
  - 'W' only: then DWID/8 data bytes, MSB first.
- FSM states: IDLE, ADDR, DATA, ISSUE, WAIT_RSP, TX_HDR, TX_DATA.
- IDLE:
  - On a popped byte 0x57/0x52: latch the op and go to ADDR.
  - Any other byte: send 0x45 'E' via TX_HDR, then return to IDLE.
- ADDR: shift AWID/8 bytes. Then go to DATA for a write, ISSUE for a read.
- DATA: shift DWID/8 bytes, then go to ISSUE.
- ISSUE:
  - Drive `msg_out` with addr = base_address + rx_addr, mod 2^AWID.
  - Hold `msg_out` stable until `msg_out_ack`=1 is sampled; `msg_out` becomes 0 the next cycle.
  - After ack, a write goes to TX_HDR with 'K' (0x4B); a read goes to WAIT_RSP.
- WAIT_RSP: a valid `msg_in` with op=11 and tag = current tag captures data and goes to TX_HDR with 'D' (0x44).
- TX_HDR: send one header byte. 'D' continues to TX_DATA; all others return to IDLE.
- TX_DATA: send DWID/8 captured bytes, MSB first, then return to IDLE.
- Timeout: a counter runs in ISSUE and WAIT_RSP.
  - It resets on entering ISSUE.
  - Reaching TMO_CYC clears `msg_out` and sends 'T' (0x54).
- Tag increments (mod 2^TWID) after each ISSUE exit, including timeout.
- Any valid `msg_in` that is not a matching response is acked and discarded, in any state.
- `enable`=0:
  - FSM is forced to IDLE and `msg_out` is cleared, with no response byte.
  - RX bytes are still popped and discarded.
  - `msg_in` is still acked.

## Timing

- Reset values: `txdata`=0, `read_rx`=0, `write_tx`=0, `msg_in_ack`=0, `msg_out`=0, `busy`=0, tag=0, timeout counter=0. FSM resets to IDLE.
- All outputs are registered.
- `read_rx`:
  - Asserted for one cycle when `rx_valid`=1 in IDLE/ADDR/DATA; the byte is captured in that same cycle.
  - Never asserted in two consecutive cycles.
- `write_tx`:
  - Asserted when `tx_empty`=1 and `write_tx` was 0 in the previous cycle.
  - `txdata` is valid in the same cycle.
- `msg_in_ack`:
  - Asserted the cycle after a valid `msg_in` is sampled.
  - Forced 0 in the following cycle; the producer must change `msg_in` within that window.
- Minimum write latency: frame last byte popped → `msg_out` valid is 1 cycle.
- `msg_out_ack` in the same cycle that `msg_out` first becomes valid is legal and honoured.
- Simultaneous matching `msg_in` and timeout expiry: the response wins.
- Reset mid-frame: the partial frame is discarded and no byte is transmitted.

## Test plan

- Write, DWID=128, base_address=0x1000_0000: RX 'W', 00 00 00 40, 16 data bytes 00..0F → `msg_out` op=01, addr=0x1000_0040, data=0x000102…0F, size=4. Ack → TX 0x4B. Tag 0→1.
- Read: RX 'R', 00 00 00 10; ack; `msg_in` op=11 with matching tag and data 0xA5…A5 → TX 0x44 then 16×0xA5. `msg_in_ack` pulses once.
- Unknown command: RX 0x3F → TX 0x45, `busy` returns to 0, no `msg_out`.
- Timeout, TMO_CYC=16: read with `msg_out_ack` held 0 → `msg_out` cleared at cycle 16, TX 0x54. A late response with the stale tag is acked, with no TX.
- Tag mismatch: in WAIT_RSP, `msg_in` tag = current+1 → acked, FSM stays in WAIT_RSP. A correct-tag response then completes normally.
- `rst` asserted after 3 address bytes → all outputs return to reset values the next cycle. A new full frame then completes correctly with tag 0.
